// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared MEM-stage encodings and FSM state type
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with handshaked data-memory port
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALURes,
    input  logic [31:0] StData,
    input  logic [4:0]  RD,
    input  logic        RegW,
    input  logic        Mem2R,
    input  logic        MemW,
    input  logic [1:0]  MemSize,
    input  logic        MemSign,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] WD,
    output logic [4:0]  RD_o,
    output logic        RegW_o,
    output logic        Mem2R_o,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0] r_rdata;
    logic        w_misalign;
    logic        w_access;
    logic        w_memop;
    logic        w_capture;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_misalign = ((MemSize == SZ_HALF) && ALURes[0]) ||
                        (MemSize[1] && (ALURes[1:0] != 2'b00));
    assign w_access   = Mem2R | MemW;
    assign w_memop    = w_access && !w_misalign;

    mem_load_align u_align (
        .i_rdata   (r_rdata),
        .i_addr_lo (ALURes[1:0]),
        .i_size    (MemSize),
        .i_sign    (MemSign),
        .o_data    (w_load)
    );

    always_comb begin
        case (MemSize)
            SZ_BYTE: begin
                w_be    = 4'b0001 << ALURes[1:0];
                w_wdata = {4{StData[7:0]}};
            end
            SZ_HALF: begin
                w_be    = ALURes[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{StData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = StData;
            end
        endcase
    end

    // Any cycle with stall=1 must push a bubble into MEM/WB, hence RegW_o stays 0 there.
    always_comb begin
        w_state_next = r_state;
        dm_req       = 1'b0;
        stall        = 1'b0;
        RegW_o       = 1'b0;
        WD           = ALURes;
        addr_err     = 1'b0;
        bus_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && w_misalign) begin
                    addr_err = 1'b1;
                end else if (w_memop) begin
                    dm_req       = 1'b1;
                    stall        = 1'b1;
                    w_state_next = dm_ready ? ST_DONE : ST_BUSY;
                end else begin
                    RegW_o = RegW;
                end
            end
            ST_BUSY: begin
                dm_req = 1'b1;
                stall  = 1'b1;
                if (dm_ready)
                    w_state_next = ST_DONE;
                else if (r_wait_cnt == CW'(MAX_WAIT - 1))
                    w_state_next = ST_ERR;
            end
            ST_DONE: begin
                RegW_o       = RegW && !MemW;
                if (Mem2R)
                    WD = w_load;
                w_state_next = ST_IDLE;
            end
            default: begin
                bus_err      = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_capture = dm_req && dm_ready && !MemW;
    assign dm_we     = dm_req & MemW;
    assign dm_addr   = dm_req ? {ALURes[31:2], 2'b00} : 32'h0;
    assign dm_be     = dm_req ? w_be : 4'b0000;
    assign dm_wdata  = dm_req ? w_wdata : 32'h0;
    assign RD_o      = RD;
    assign Mem2R_o   = Mem2R;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_BUSY && w_state_next == ST_BUSY)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (w_capture)
                r_rdata <= dm_rdata;
        end
    end

endmodule
